// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   Registers each decoded instruction, resolves EX/MEM and MEM/WB
//   forwarding onto the ALU operands, detects hazards that need a stall,
//   and loads bubbles on stall or flush.
//
// Config macro: ID_EX_FORWARD_EN
//   defined   : operands are forwarded; only load-use stalls.
//   undefined : operands use latched register-file data; any RAW on the
//               EX or EX/MEM destination stalls (MEM/WB is covered by a
//               first-half-cycle register-file write).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   id_*                  decoded instruction in the decode slot
//   flush                 squash the decode slot
//   exmem_*, memwb_*      forwarding sources from later stages
//   id_stall              combinational: hold PC and IF/ID this cycle
//   ex_*                  registered ALU-side fields and forwarded operands
//   stall_count           saturating count of stall bubbles

// Per-source forwarding mux: picks the youngest in-flight result that
// targets this source register, else the latched register-file value.
module id_ex_fwd_mux (
  input  logic [4:0]  src,
  input  logic [31:0] val,
  input  logic        exmem_regWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] fwd
);
`ifdef ID_EX_FORWARD_EN
  always_comb begin
    fwd = val;
    // r0 is hardwired zero, so a write "to r0" must never be forwarded
    if (src != 5'd0) begin
      if (exmem_regWrite && exmem_rd == src)      fwd = exmem_result;
      else if (memwb_regWrite && memwb_rd == src) fwd = memwb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{src, exmem_regWrite, exmem_rd, exmem_result,
                        memwb_regWrite, memwb_rd, memwb_result};
  assign fwd = val;
`endif
endmodule

module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [2:0]             id_aluOp,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [31:0]            id_rsVal,
  input  logic [31:0]            id_rtVal,
  input  logic                   id_aluSrc,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   id_jump,
  input  logic                   id_branch,
  input  logic [31:0]            id_pc,
  input  logic [25:0]            id_addrInfo,
  input  logic                   flush,
  input  logic                   exmem_regWrite,
  input  logic [4:0]             exmem_rd,
  input  logic [31:0]            exmem_result,
  input  logic                   memwb_regWrite,
  input  logic [4:0]             memwb_rd,
  input  logic [31:0]            memwb_result,
  output logic                   id_stall,
  output logic                   ex_valid,
  output logic                   ex_regWrite,
  output logic                   ex_memRead,
  output logic                   ex_jump,
  output logic                   ex_branch,
  output logic [2:0]             ex_aluOp,
  output logic [4:0]             ex_rd,
  output logic [31:0]            ex_pc,
  output logic [25:0]            ex_addrInfo,
  output logic [31:0]            ex_operand1,
  output logic [31:0]            ex_operand2,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam int NUM_SRC = 2;  // rs, rt

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        jump;
    logic        branch;
    logic [2:0]  aluOp;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        aluSrc;
    logic [31:0] pc;
    logic [25:0] addrInfo;
  } ex_t;

  ex_t ex_q;

  // ---------------------------------------------------------------- hazard
  function automatic logic dep(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt, input logic alu_src);
    // rt is only a real source when operand2 is not the immediate
    return (r != 5'd0) && (r == rs || (!alu_src && r == rt));
  endfunction

`ifdef ID_EX_FORWARD_EN
  // Only a load in EX cannot be forwarded in time.
  assign id_stall = id_valid && ex_q.valid && ex_q.memRead &&
                    dep(ex_q.rd, id_rs, id_rt, id_aluSrc);
`else
  assign id_stall = id_valid &&
                    ((ex_q.valid && ex_q.regWrite && dep(ex_q.rd, id_rs, id_rt, id_aluSrc)) ||
                     (exmem_regWrite && dep(exmem_rd, id_rs, id_rt, id_aluSrc)));
`endif

  // --------------------------------------------------------------- register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_count <= '0;
    end else if (flush || id_stall) begin
      // Bubble: kill control and register ids; data fields hold.
      ex_q.valid    <= 1'b0;
      ex_q.regWrite <= 1'b0;
      ex_q.memRead  <= 1'b0;
      ex_q.jump     <= 1'b0;
      ex_q.branch   <= 1'b0;
      ex_q.rd       <= 5'd0;
      ex_q.rs       <= 5'd0;
      ex_q.rt       <= 5'd0;
      if (!flush && stall_count != {STALL_CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end else begin
      ex_q.valid    <= id_valid;
      ex_q.regWrite <= id_regWrite;
      ex_q.memRead  <= id_memRead;
      ex_q.jump     <= id_jump;
      ex_q.branch   <= id_branch;
      ex_q.aluOp    <= id_aluOp;
      ex_q.rd       <= id_rd;
      ex_q.rs       <= id_rs;
      ex_q.rt       <= id_rt;
      ex_q.rsVal    <= id_rsVal;
      ex_q.rtVal    <= id_rtVal;
      ex_q.aluSrc   <= id_aluSrc;
      ex_q.pc       <= id_pc;
      ex_q.addrInfo <= id_addrInfo;
    end
  end

  // ------------------------------------------------------------ forwarding
  logic [NUM_SRC-1:0][4:0]  src_reg;
  logic [NUM_SRC-1:0][31:0] src_val;
  logic [NUM_SRC-1:0][31:0] fwd_val;

  assign src_reg[0] = ex_q.rs;
  assign src_reg[1] = ex_q.rt;
  assign src_val[0] = ex_q.rsVal;
  assign src_val[1] = ex_q.rtVal;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    id_ex_fwd_mux u_fwd (
      .src            (src_reg[g]),
      .val            (src_val[g]),
      .exmem_regWrite (exmem_regWrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regWrite (memwb_regWrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd            (fwd_val[g])
    );
  end

  // --------------------------------------------------------------- outputs
  assign ex_valid    = ex_q.valid;
  assign ex_regWrite = ex_q.regWrite;
  assign ex_memRead  = ex_q.memRead;
  assign ex_jump     = ex_q.jump;
  assign ex_branch   = ex_q.branch;
  assign ex_aluOp    = ex_q.aluOp;
  assign ex_rd       = ex_q.rd;
  assign ex_pc       = ex_q.pc;
  assign ex_addrInfo = ex_q.addrInfo;
  assign ex_operand1 = fwd_val[0];
  // The immediate comes straight from the instruction word; never forwarded.
  assign ex_operand2 = ex_q.aluSrc ? {{16{ex_q.addrInfo[15]}}, ex_q.addrInfo[15:0]}
                                   : fwd_val[1];
endmodule
